// File: rtl/dom_sched_pkg.sv
// Shared types and sizing for the DOM AND gadget sequencer.
package dom_sched_pkg;

  localparam int unsigned SHARES = 5;

  // One fresh random bit per unordered share pair.
  function automatic int unsigned rand_bits(input int unsigned shares);
    return shares * (shares - 1) / 2;
  endfunction

  localparam int unsigned RAND_BITS  = rand_bits(SHARES);
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned CNT_W_DEF  = 16;

  typedef logic [SHARES-1:0]    share_t;
  typedef logic [RAND_BITS-1:0] rand_t;
  typedef logic                 req_id_t;

  typedef struct packed {
    req_id_t id;
    share_t  data;
  } res_entry_t;

endpackage

// File: rtl/dom_and_sched_if.sv
// Requester, randomness, gadget and result signals of the DOM AND sequencer.
interface dom_and_sched_if #(
  parameter int unsigned CNT_W = 16
);
  import dom_sched_pkg::*;

  logic             req0_valid;
  logic             req0_ready;
  share_t           req0_a;
  share_t           req0_b;
  logic             req1_valid;
  logic             req1_ready;
  share_t           req1_a;
  share_t           req1_b;
  logic             rnd_valid;
  logic             rnd_ready;
  rand_t            rnd_data;
  share_t           g_a;
  share_t           g_b;
  rand_t            g_rand;
  share_t           g_o;
  logic             res_valid;
  logic             res_ready;
  share_t           res_data;
  req_id_t          res_id;
  logic [CNT_W-1:0] rnd_used;

  // Environment side: requesters, RNG, gadget and result consumer.
  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output rnd_valid, rnd_data,
    output g_o,
    output res_ready,
    input  req0_ready, req1_ready, rnd_ready,
    input  g_a, g_b, g_rand,
    input  res_valid, res_data, res_id, rnd_used
  );

  // Sequencer side.
  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  rnd_valid, rnd_data,
    input  g_o,
    input  res_ready,
    output req0_ready, req1_ready, rnd_ready,
    output g_a, g_b, g_rand,
    output res_valid, res_data, res_id, rnd_used
  );

endinterface

// File: rtl/dom_sched_res_fifo.sv
// Two-entry in-order buffer for gadget results tagged with requester ID.
module dom_sched_res_fifo
  import dom_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  res_entry_t push_data,
  input  logic       pop,
  output res_entry_t head,
  output logic [1:0] count
);

  res_entry_t mem [FIFO_DEPTH];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr_q] <= push_data;
        wr_ptr_q      <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_q + 2'(push) - 2'(pop);
    end
  end

  // Empty buffer presents zeros rather than stale data.
  assign head  = (cnt_q != 2'd0) ? mem[rd_ptr_q] : '0;
  assign count = cnt_q;

endmodule

// File: rtl/dom_and_sched.sv
// Round-robin sequencer feeding one shared DOM AND gadget with fresh randomness.
module dom_and_sched
  import dom_sched_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input logic            clock_0,
  input logic            reset_0,
  dom_and_sched_if.slave bus
);

  logic             inflight_q;
  req_id_t          inflight_id_q;
  req_id_t          last_grant_q;
  logic [CNT_W-1:0] cnt_q;

  logic             slot_free_c;
  logic             issue_c;
  req_id_t          grant_c;
  logic             pop_c;
  logic [1:0]       fifo_count;
  res_entry_t       fifo_head;
  res_entry_t       fifo_push_data;

  // A pop in the same cycle frees the slot the new result will need.
  assign pop_c       = bus.res_valid & bus.res_ready;
  assign slot_free_c = ((fifo_count + 2'(inflight_q)) < 2'd2) | pop_c;

  always_comb begin
    grant_c = req_id_t'(bus.req1_valid);
    if (bus.req0_valid && bus.req1_valid) begin
      grant_c = ~last_grant_q;
    end
    issue_c = (bus.req0_valid | bus.req1_valid) & bus.rnd_valid & slot_free_c & reset_0;
  end

  // Gadget operands are zeroed whenever nothing issues.
  always_comb begin
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.rnd_ready  = 1'b0;
    bus.g_a        = '0;
    bus.g_b        = '0;
    bus.g_rand     = '0;
    if (issue_c) begin
      bus.rnd_ready = 1'b1;
      bus.g_rand    = bus.rnd_data;
      if (grant_c) begin
        bus.req1_ready = 1'b1;
        bus.g_a        = bus.req1_a;
        bus.g_b        = bus.req1_b;
      end else begin
        bus.req0_ready = 1'b1;
        bus.g_a        = bus.req0_a;
        bus.g_b        = bus.req0_b;
      end
    end
  end

  always_ff @(posedge clock_0 or negedge reset_0) begin
    if (!reset_0) begin
      inflight_q    <= 1'b0;
      inflight_id_q <= 1'b0;
      last_grant_q  <= 1'b1;
      cnt_q         <= '0;
    end else begin
      inflight_q <= issue_c;
      if (issue_c) begin
        inflight_id_q <= grant_c;
        last_grant_q  <= grant_c;
        if (cnt_q != '1) begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign fifo_push_data = '{id: inflight_id_q, data: bus.g_o};

  dom_sched_res_fifo u_res_fifo (
    .clk       (clock_0),
    .rst_n     (reset_0),
    .push      (inflight_q),
    .push_data (fifo_push_data),
    .pop       (pop_c),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign bus.res_valid = (fifo_count != 2'd0);
  assign bus.res_data  = fifo_head.data;
  assign bus.res_id    = fifo_head.id;
  assign bus.rnd_used  = cnt_q;

endmodule

// File: doc/dom_and_sched.md
# dom_and_sched

Sequencer and arbiter in front of one shared 5-share (order-4) DOM AND gadget. Accepts masked operand pairs from two requesters, grants the gadget round-robin, pairs every issue with exactly one fresh 10-bit randomness word, and tracks the gadget's one-cycle register latency. Gadget results go into a 2-entry result buffer tagged with the requester ID. Sits between the masked S-box/round controllers and the gadget instance.

## Interface
- SHARES, 5, shares per masked bit (d+1)
- RAND_BITS, SHARES*(SHARES-1)/2 = 10, derived, not overridable
- CNT_W, 16, width of the randomness-usage counter
- clock_0  in  1  single clock, rising edge
- reset_0  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  operand pair offered
- req0_ready / req1_ready  out  1  operand pair accepted this cycle
- req0_a, req0_b, req1_a, req1_b  in  SHARES  operand share vectors, bit i = share i
- rnd_valid  in  1  fresh randomness word available
- rnd_ready  out  1  word consumed this cycle
- rnd_data  in  RAND_BITS  randomness word
- g_a, g_b  out  SHARES  gadget operand shares
- g_rand  out  RAND_BITS  gadget randomness (bit k maps to gadget p_rand_k)
- g_o  in  SHARES  gadget output shares, valid one cycle after issue
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  SHARES  result share vector
- res_id  out  1  requester that issued the result
- rnd_used  out  CNT_W  saturating count of consumed randomness words

## Operation
- Issue condition (cycle t): at least one reqN_valid, rnd_valid=1, and slot_free. slot_free = (fifo_count + inflight < 2) or (res_valid and res_ready).
- Arbitration: 2-way round-robin; last_grant register; requester != last_grant wins when both valid. Reset value of last_grant = 1, so req0 wins the first contention.
- On issue: reqN_ready=1 for granted requester only, rnd_ready=1, g_a/g_b/g_rand driven from granted operands and rnd_data, inflight<=1, inflight_id<=N, last_grant<=N, rnd_used increments (saturates at 2^CNT_W-1).
- No issue: all ready outputs 0; g_a, g_b, g_rand driven to all-zero. No randomness word is ever presented to the gadget twice or consumed without an issue.
- Capture: when inflight=1, g_o and inflight_id are written to FIFO tail; inflight cleared unless a new issue occurs in the same cycle.
- FIFO: 2 entries, in-order; head drives res_data/res_id; res_valid = count>0. Pop on res_valid and res_ready. Simultaneous push and pop keep count unchanged.
- res_ready low: buffer fills; issues stop once count+inflight reaches 2; never overflows, never drops.
- reqN_ready is combinational from valids, rnd_valid, slot_free, last_grant; valid must not depend on ready.

## Timing
- Reset (async assert, sync deassert): all ready outputs 0, res_valid 0, res_data 0, res_id 0, g_* 0, rnd_used 0, inflight 0, FIFO empty, last_grant 1.
- Reset mid-operation discards in-flight and buffered results; no res_valid after release until a new issue.
- Latency: accept at edge ending cycle t -> g_o valid in t+1 -> res_valid in t+2.
- Throughput: one issue per cycle with res_ready=1 and rnd_valid=1.
- rnd_valid=0 stalls issue regardless of requests; operands held by requesters.

## Structure
- Package dom_sched_pkg: SHARES, RAND_BITS function, share-vector and randomness-word typedefs, requester-ID typedef.
- Sub-module dom_sched_res_fifo: 2-entry result/ID FIFO with count output. Arbiter and issue logic stay in top.

## Test plan
- Single op: req0_a=5'b00001 (a=1), req0_b=5'b00011 (b=0), rnd_data=10'h2A5 -> issue at t, res_valid at t+2, XOR(res_data)=0, res_id=0, rnd_used=1.
- Contention: both valid continuously, res_ready=1, a=b=1 -> grants alternate 0,1,0,1 from reset; every result XOR=1; one issue per cycle.
- Randomness starvation: rnd_valid low 3 cycles with req0_valid high -> req0_ready, rnd_ready stay 0, g_* all-zero; issue in first cycle rnd_valid returns.
- Back-pressure: res_ready=0, 4 requests -> exactly 2 accepted, third ready=0 until pop; release res_ready -> results in issue order, none lost.
- Reset mid-flight: reset_0 low the cycle after issue -> res_valid 0 after release, rnd_used=0, last_grant=1.
- Saturation: CNT_W=4, 20 issues -> rnd_used holds 15.
